mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-requester (I-fetch / D-read) arbiter onto one memory port.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
// Ports: clk, reset_n (async, active low);
//   i_req/i_addr/i_ack/i_rdata : instruction read channel
//   d_req/d_addr/d_ack/d_rdata : data read channel
//   m_req/m_addr/m_ack/m_rdata : shared memory read channel
module mem_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic [XLEN-1:0] d_addr,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req,
  output logic [XLEN-1:0] m_addr,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            m_req_q, m_req_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic            tie_to_d;
  logic            pick_d;
  logic            any_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = I, 1 = D; reset to I so the first tie goes to D
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && any_req) begin
      last_grant_d = pick_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b0;
    else          last_grant_q <= last_grant_d;
  end

  assign tie_to_d = ~last_grant_q;
`else
  assign tie_to_d = 1'b1;
`endif

  assign any_req = i_req | d_req;
  assign pick_d  = d_req & (~i_req | tie_to_d);

  always_comb begin
    state_d  = state_q;
    m_req_d  = m_req_q;
    m_addr_d = m_addr_q;
    case (state_q)
      IDLE: begin
        // m_ack here is stale or spurious and is ignored
        if (any_req) begin
          state_d  = pick_d ? BUSY_D : BUSY_I;
          m_req_d  = 1'b1;
          m_addr_d = pick_d ? d_addr : i_addr;
        end
      end
      BUSY_I, BUSY_D: begin
        // requester dropping its req does not abort
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      m_req_q  <= 1'b0;
      m_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      m_req_q  <= m_req_d;
      m_addr_q <= m_addr_d;
    end
  end

  assign m_req  = m_req_q;
  assign m_addr = m_addr_q;

  assign i_ack   = (state_q == BUSY_I) & m_ack;
  assign d_ack   = (state_q == BUSY_D) & m_ack;
  assign i_rdata = (state_q == BUSY_I) ? m_rdata : '0;
  assign d_rdata = (state_q == BUSY_D) ? m_rdata : '0;

endmodule
